// File: rtl/fp_mul_pipe.sv
// Multicycle floating-point multiplier with a start/done/serv handshake.
// It rounds to nearest-even, flushes denormal inputs to zero and reports {nv, of, uf, nx}.
module fp_mul_pipe #(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned MAN_W   = 23,
  parameter int unsigned LATENCY = 5
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   mul_start,
  input  logic                   mul_serv,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   mul_result,
  output logic [3:0]             mul_flags,
  output logic                   mul_busy,
  output logic                   mul_done
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned PW   = 2 * MAN_W + 2;
  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   result_q;
  logic [3:0]     flags_q;

  logic                   sign_a, sign_b, sign_r;
  logic [EXP_W-1:0]       exp_a, exp_b;
  logic [MAN_W-1:0]       frac_a, frac_b;
  logic                   zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [PW-1:0]          prod;
  logic [PW-2:0]          norm;
  logic [MAN_W-1:0]       frac_t, frac_r;
  logic                   guard, sticky, round_up, carry;
  logic [MAN_W+1:0]       man_rnd;
  logic signed [XW-1:0]   exp_sum;
  logic                   ovf, und;
  logic [W-1:0]           res_d;
  logic [3:0]             flags_d;

  always_comb begin
    sign_a = a_q[W-1];
    sign_b = b_q[W-1];
    exp_a  = a_q[W-2:MAN_W];
    exp_b  = b_q[W-2:MAN_W];
    frac_a = a_q[MAN_W-1:0];
    frac_b = b_q[MAN_W-1:0];
    sign_r = sign_a ^ sign_b;

    // exp=0 covers true zero and denormals, which are flushed without a flag
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
    inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
    nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
    nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
  end

  // Normalise so the leading one sits just above norm's top bit; the shift-in zero
  // cannot disturb sticky.
  always_comb begin
    prod     = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
    norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    frac_t   = norm[PW-2 -: MAN_W];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | frac_t[0]);
    man_rnd  = {1'b0, 1'b1, frac_t} + (MAN_W+2)'(round_up);
    carry    = man_rnd[MAN_W+1];
    frac_r   = carry ? man_rnd[MAN_W:1] : man_rnd[MAN_W-1:0];
    exp_sum  = $signed(XW'(exp_a)) + $signed(XW'(exp_b)) - $signed(XW'(BIAS))
             + $signed(XW'(prod[PW-1])) + $signed(XW'(carry));
    ovf      = exp_sum >= $signed({2'b00, EXP_ONES});
    und      = exp_sum <= $signed(XW'(0));
  end

  always_comb begin
    res_d   = {sign_r, exp_sum[EXP_W-1:0], frac_r};
    flags_d = {3'b000, guard | sticky};
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      res_d   = QNAN;
      flags_d = 4'b1000;
    end else if (inf_a || inf_b) begin
      res_d   = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (zero_a || zero_b) begin
      res_d   = {sign_r, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (ovf) begin
      res_d   = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (und) begin
      res_d   = {sign_r, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mul_start) begin
            a_q     <= op1;
            b_q     <= op2;
            cnt_q   <= 4'(LATENCY);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd1) begin
            result_q <= res_d;
            flags_q  <= flags_d;
            cnt_q    <= '0;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          if (mul_serv) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mul_result = result_q;
  assign mul_flags  = flags_q;
  assign mul_busy   = (state_q == StBusy);
  assign mul_done   = (state_q == StDone);

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: literal vectors plus a per-cycle compare against
// an exact-integer rounding model and a timestamp-based handshake model.
module tb_fp_mul_pipe;

  localparam int unsigned LAT = 5;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        mul_start, mul_serv;
  logic [31:0] op1, op2, mul_result;
  logic [3:0]  mul_flags;
  logic        mul_busy, mul_done;

  logic        s_start, s_serv;
  logic [15:0] s_op1, s_op2, s_result;
  logic [3:0]  s_flags;
  logic        s_busy, s_done;

  int checks   = 0;
  int failures = 0;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .mul_start(mul_start), .mul_serv(mul_serv),
    .op1(op1), .op2(op2), .mul_result(mul_result), .mul_flags(mul_flags),
    .mul_busy(mul_busy), .mul_done(mul_done)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .LATENCY(1)) dut_small (
    .clk(clk), .n_rst(n_rst), .mul_start(s_start), .mul_serv(s_serv),
    .op1(s_op1), .op2(s_op2), .mul_result(s_result), .mul_flags(s_flags),
    .mul_busy(s_busy), .mul_done(s_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Exact product as an integer, rounded by comparing the discarded remainder to half an ulp.
  // Returns {flags, result} with the result in the low bits.
  function automatic logic [35:0] ref_mul(input int ew, input int mw,
                                          input longint unsigned a, input longint unsigned b);
    longint unsigned ones, mask, fa, fb, ea, eb, p, q, rem, half;
    longint e;
    int len, sh, bias;
    logic s, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    bias = (1 << (ew - 1)) - 1;
    ones = (longint'(1) << ew) - 1;
    mask = (longint'(1) << mw) - 1;
    s  = ((a >> (ew + mw)) & 1) != ((b >> (ew + mw)) & 1);
    ea = (a >> mw) & ones;  eb = (b >> mw) & ones;
    fa = a & mask;          fb = b & mask;
    nan_a = ea == ones && fa != 0;  nan_b = eb == ones && fb != 0;
    inf_a = ea == ones && fa == 0;  inf_b = eb == ones && fb == 0;
    z_a = ea == 0;  z_b = eb == 0;
    if (nan_a || nan_b || (inf_a && z_b) || (z_a && inf_b))
      return {4'b1000, 32'((ones << mw) | (longint'(1) << (mw - 1)))};
    if (inf_a || inf_b)
      return {4'b0000, 32'((longint'(s) << (ew + mw)) | (ones << mw))};
    if (z_a || z_b)
      return {4'b0000, 32'(longint'(s) << (ew + mw))};
    p = ((longint'(1) << mw) | fa) * ((longint'(1) << mw) | fb);
    len = 0;
    for (int i = 0; i < 64; i++) if ((p >> i) != 0) len = i + 1;
    sh   = len - (mw + 1);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (longint'(1) << (mw + 1))) begin
      q = q >> 1;
      len++;
    end
    e = longint'(ea) + longint'(eb) - bias + (len - 1) - 2 * mw;
    if (e >= longint'(ones))
      return {4'b0101, 32'((longint'(s) << (ew + mw)) | (ones << mw))};
    if (e <= 0)
      return {4'b0011, 32'(longint'(s) << (ew + mw))};
    return {3'b000, rem != 0, 32'((longint'(s) << (ew + mw)) | (longint'(e) << mw) | (q & mask))};
  endfunction

  // Handshake model: completion lands LAT edges after the accepting edge.
  int          cyc, t_acc;
  logic        active, m_done;
  logic [35:0] m_pend, m_out;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cyc <= 0; t_acc <= 0; active <= 1'b0; m_done <= 1'b0; m_pend <= '0; m_out <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!active && !m_done && mul_start) begin
        active <= 1'b1;
        t_acc  <= cyc;
        m_pend <= ref_mul(8, 23, op1, op2);
      end
      if (active && (cyc - t_acc) == LAT) begin
        active <= 1'b0;
        m_done <= 1'b1;
        m_out  <= m_pend;
      end
      if (m_done && mul_serv) m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      check("cmp_busy", mul_busy, active);
      check("cmp_done", mul_done, m_done);
      check("cmp_result", mul_result, m_out[31:0]);
      check("cmp_flags", mul_flags, m_out[35:32]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    op1 = a; op2 = b; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    op1 = $urandom; op2 = $urandom;
  endtask

  task automatic wait_done(input string name, input int exp_len, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl);
    int n = 0;
    while (mul_busy && n < 40) begin
      n++;
      tick();
    end
    check({name, "_busy_len"}, n, exp_len);
    check({name, "_done"}, mul_done, 1'b1);
    check({name, "_result"}, mul_result, res);
    check({name, "_flags"}, mul_flags, fl);
    check({name, "_model"}, ref_mul(8, 23, a, b), {fl, res});
  endtask

  task automatic serv();
    mul_serv = 1'b1;
    tick();
    mul_serv = 1'b0;
    check("serv_done_low", mul_done, 1'b0);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [3:0] fl);
    start_op(a, b);
    wait_done(name, LAT, a, b, res, fl);
    serv();
  endtask

  initial begin
    n_rst = 1'b0; mul_start = 1'b0; mul_serv = 1'b0; op1 = '0; op2 = '0;
    s_start = 1'b0; s_serv = 1'b0; s_op1 = '0; s_op2 = '0;
    #3;
    check("rst_result", mul_result, 32'h0);
    check("rst_flags", mul_flags, 4'h0);
    check("rst_busy", mul_busy, 1'b0);
    check("rst_done", mul_done, 1'b0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    tick();

    run("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run("mul_m2x3",    32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    run("rnd_up",      32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    run("rnd_down",    32'h3F800001, 32'h3F7FFFFF, 32'h3F800000, 4'b0001);
    run("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run("nan_x_one",   32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run("ninf_x_2",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run("denorm_x_2",  32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    run("overflow",    32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    run("underflow",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);

    // Starts while busy and while done must be ignored.
    start_op(32'h3FC00000, 32'h40000000);
    repeat (2) begin
      op1 = 32'h7F800000; op2 = 32'h0; mul_start = 1'b1;
      tick();
      mul_start = 1'b0;
    end
    wait_done("busy_start", LAT - 2, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    op1 = 32'h7F800000; op2 = 32'h0; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    check("done_start_done", mul_done, 1'b1);
    check("done_start_result", mul_result, 32'h40400000);
    repeat (10) tick();
    check("done_held", mul_done, 1'b1);

    // serv and start together: back to idle, no new operation.
    mul_serv = 1'b1; mul_start = 1'b1; op1 = 32'h3F800000; op2 = 32'h40000000;
    tick();
    mul_serv = 1'b0; mul_start = 1'b0;
    check("serv_start_busy", mul_busy, 1'b0);
    check("serv_start_done", mul_done, 1'b0);
    tick();
    check("serv_start_busy2", mul_busy, 1'b0);
    check("serv_start_result", mul_result, 32'h40400000);

    // Asynchronous reset in the third busy cycle.
    start_op(32'hC0000000, 32'h40400000);
    tick();
    tick();
    check("pre_rst_busy", mul_busy, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_result", mul_result, 32'h0);
    check("midrst_flags", mul_flags, 4'h0);
    check("midrst_busy", mul_busy, 1'b0);
    check("midrst_done", mul_done, 1'b0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    tick();
    run("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

    // Half-precision-like instance with single-cycle latency.
    s_op1 = 16'h3E00; s_op2 = 16'h4000; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("small_busy", s_busy, 1'b1);
    check("small_done_early", s_done, 1'b0);
    tick();
    check("small_done", s_done, 1'b1);
    check("small_result", s_result, 16'h4200);
    check("small_flags", s_flags, 4'h0);
    check("small_model", ref_mul(5, 10, 16'h3E00, 16'h4000), {4'h0, 32'h00004200});
    s_serv = 1'b1;
    tick();
    s_serv = 1'b0;
    check("small_serv", s_done, 1'b0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
